// File: rtl/aes_cone_pkg.sv
// Shared types and constants for the AES cone launch/capture stage.
// The FSM state encoding and default parameter values live here.
package aes_cone_pkg;

  localparam int CONE_IN_W = 13;
  localparam logic [15:0] DEFAULT_MISR_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/aes_cone_launch_capture_if.sv
// Vector-in / result-out handshake bundle for the launch/capture stage.
// The master modport is the upstream/downstream side; the slave modport is the stage.
interface aes_cone_launch_capture_if #(
  parameter int IN_W = 13
);
  logic            vec_valid;
  logic [IN_W-1:0] vec_data;
  logic            vec_ready;
  logic            res_valid;
  logic            res_bit;
  logic            res_ready;

  modport master (
    output vec_valid, vec_data, res_ready,
    input  vec_ready, res_valid, res_bit
  );

  modport slave (
    input  vec_valid, vec_data, res_ready,
    output vec_ready, res_valid, res_bit
  );
endinterface

// File: rtl/aes_cone_misr.sv
// Single-input MISR: shift left, XOR polynomial when the MSB falls out, XOR data into bit 0.
// Synchronous clear has priority over a same-cycle update.
module aes_cone_misr #(
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic              din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_reg;
  logic [MISR_W-1:0] sig_next;

  assign sig_next[0] = (sig_reg[MISR_W-1] & MISR_POLY[0]) ^ din;

  for (genvar gi = 1; gi < MISR_W; gi++) begin : g_shift
    assign sig_next[gi] = sig_reg[gi-1] ^ (sig_reg[MISR_W-1] & MISR_POLY[gi]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_reg <= '0;
    end else if (clear) begin
      sig_reg <= '0;
    end else if (en) begin
      sig_reg <= sig_next;
    end
  end

  assign sig = sig_reg;

endmodule

// File: rtl/aes_cone_launch_capture.sv
// Launch a vector onto the cone from flops, wait SETTLE_CYC cycles, capture the output bit
// and hand it downstream; every capture is folded into a MISR and counted.
module aes_cone_launch_capture
  import aes_cone_pkg::*;
#(
  parameter int                IN_W       = CONE_IN_W,
  parameter int                SETTLE_CYC = 1,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = DEFAULT_MISR_POLY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  aes_cone_launch_capture_if.slave bus,
  output logic [IN_W-1:0]        cone_in,
  input  logic                   cone_out,
  input  logic                   clear,
  output logic [MISR_W-1:0]      sig,
  output logic [15:0]            cap_cnt
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t          state_reg;
  logic [3:0]      settle_cnt_reg;
  logic [IN_W-1:0] cone_in_reg;
  logic            res_bit_reg;
  logic            res_valid_reg;
  logic            vec_ready_reg;
  logic [15:0]     cap_cnt_reg;
  logic            capture;

  // The capture edge is the edge on which WAIT sees an exhausted settle counter.
  assign capture = (state_reg == WAIT) && (settle_cnt_reg == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= 4'd0;
      cone_in_reg    <= '0;
      res_bit_reg    <= 1'b0;
      res_valid_reg  <= 1'b0;
      vec_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.vec_valid) begin
            cone_in_reg    <= bus.vec_data;
            settle_cnt_reg <= SETTLE_LOAD;
            vec_ready_reg  <= 1'b0;
            state_reg      <= WAIT;
          end
        end
        WAIT: begin
          if (settle_cnt_reg != 4'd0) begin
            settle_cnt_reg <= settle_cnt_reg - 4'd1;
          end else begin
            res_bit_reg   <= cone_out;
            res_valid_reg <= 1'b1;
            state_reg     <= RESULT;
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            vec_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          res_valid_reg <= 1'b0;
          vec_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_cnt_reg <= 16'd0;
    end else if (clear) begin
      cap_cnt_reg <= 16'd0;
    end else if (capture && (cap_cnt_reg != 16'hFFFF)) begin
      cap_cnt_reg <= cap_cnt_reg + 16'd1;
    end
  end

  aes_cone_misr #(
    .MISR_W    (MISR_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .en    (capture),
    .din   (cone_out),
    .sig   (sig)
  );

  assign cone_in       = cone_in_reg;
  assign cap_cnt       = cap_cnt_reg;
  assign bus.vec_ready = vec_ready_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_bit   = res_bit_reg;

endmodule

// File: tb/tb_aes_cone_launch_capture.sv
// Directed bench for the launch/capture stage: one default-settle instance and one
// SETTLE_CYC=4 instance sharing clock and reset; inputs change and outputs are sampled on negedge.
module tb_aes_cone_launch_capture;

  logic        clk;
  logic        rst_n;
  logic        cone_out;
  logic        clear;
  logic [12:0] cone_in;
  logic [15:0] sig;
  logic [15:0] cap_cnt;

  logic        cone_out4;
  logic        clear4;
  logic [12:0] cone_in4;
  logic [15:0] sig4;
  logic [15:0] cap_cnt4;

  int n_vec;
  int n_bad;

  aes_cone_launch_capture_if #(.IN_W(13)) bus ();
  aes_cone_launch_capture_if #(.IN_W(13)) bus4 ();

  aes_cone_launch_capture dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cone_in  (cone_in),
    .cone_out (cone_out),
    .clear    (clear),
    .sig      (sig),
    .cap_cnt  (cap_cnt)
  );

  aes_cone_launch_capture #(.SETTLE_CYC(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus4),
    .cone_in  (cone_in4),
    .cone_out (cone_out4),
    .clear    (clear4),
    .sig      (sig4),
    .cap_cnt  (cap_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on the default instance, starting and ending at a negedge in IDLE.
  task automatic txn(input logic [12:0] d, input logic c);
    bus.vec_valid = 1'b1;
    bus.vec_data  = d;
    cone_out      = c;
    @(negedge clk);
    bus.vec_valid = 1'b0;
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    cone_out = 1'b0;
    clear = 1'b0;
    cone_out4 = 1'b0;
    clear4 = 1'b0;
    bus.vec_valid = 1'b0;
    bus.vec_data = 13'h0;
    bus.res_ready = 1'b0;
    bus4.vec_valid = 1'b0;
    bus4.vec_data = 13'h0;
    bus4.res_ready = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vec_ready", 32'(bus.vec_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_sig",       32'(sig),           32'h0000);
    chk("rst_cap_cnt",   32'(cap_cnt),       32'd0);
    chk("rst_cone_in",   32'(cone_in),       32'h0);

    // Single transaction, default settle
    bus.vec_valid = 1'b1;
    bus.vec_data  = 13'h1ABC;
    cone_out      = 1'b1;
    @(negedge clk);
    bus.vec_valid = 1'b0;
    chk("t1_cone_in",   32'(cone_in),       32'h1ABC);
    chk("t1_vec_ready", 32'(bus.vec_ready), 32'd0);
    chk("t1_res_early", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    chk("t1_res_valid", 32'(bus.res_valid), 32'd1);
    chk("t1_res_bit",   32'(bus.res_bit),   32'd1);
    chk("t1_sig",       32'(sig),           32'h0001);
    chk("t1_cap_cnt",   32'(cap_cnt),       32'd1);

    // Backpressure: result held, pending vector not accepted
    bus.vec_valid = 1'b1;
    bus.vec_data  = 13'h0555;
    cone_out      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_res_bit",   32'(bus.res_bit),   32'd1);
      chk("bp_vec_ready", 32'(bus.vec_ready), 32'd0);
      chk("bp_cone_in",   32'(cone_in),       32'h1ABC);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("bp_rel_res_valid", 32'(bus.res_valid), 32'd0);
    chk("bp_rel_vec_ready", 32'(bus.vec_ready), 32'd1);
    chk("bp_rel_cone_in",   32'(cone_in),       32'h1ABC);
    @(negedge clk);
    bus.vec_valid = 1'b0;
    chk("bp_acc_cone_in",   32'(cone_in),       32'h0555);
    chk("bp_acc_vec_ready", 32'(bus.vec_ready), 32'd0);
    @(negedge clk);
    chk("bp_res_bit0", 32'(bus.res_bit), 32'd0);
    chk("bp_sig",      32'(sig),         32'h0002);
    chk("bp_cap_cnt",  32'(cap_cnt),     32'd2);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;

    // Clear in IDLE leaves the FSM alone
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_sig",       32'(sig),           32'h0000);
    chk("clr_cap_cnt",   32'(cap_cnt),       32'd0);
    chk("clr_vec_ready", 32'(bus.vec_ready), 32'd1);
    chk("clr_cone_in",   32'(cone_in),       32'h0555);

    // MISR feedback: build 0x8000, then shift out the MSB with a 0 captured
    txn(13'h0001, 1'b1);
    for (int i = 0; i < 15; i++) txn(13'(i + 2), 1'b0);
    chk("misr_preload", 32'(sig),     32'h8000);
    chk("misr_cnt16",   32'(cap_cnt), 32'd16);
    txn(13'h1FFF, 1'b0);
    chk("misr_fb", 32'(sig), 32'h1021);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    txn(13'h0AAA, 1'b1);
    chk("misr_1", 32'(sig), 32'h0001);
    txn(13'h1555, 1'b1);
    chk("misr_3",     32'(sig),     32'h0003);
    chk("misr_cnt2",  32'(cap_cnt), 32'd2);

    // Clear coinciding with the capture edge
    bus.vec_valid = 1'b1;
    bus.vec_data  = 13'h0123;
    cone_out      = 1'b1;
    @(negedge clk);
    bus.vec_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clrcap_sig",       32'(sig),           32'h0000);
    chk("clrcap_cap_cnt",   32'(cap_cnt),       32'd0);
    chk("clrcap_res_valid", 32'(bus.res_valid), 32'd1);
    chk("clrcap_res_bit",   32'(bus.res_bit),   32'd1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;

    // Counter saturation
    force dut.cap_cnt_reg = 16'hFFFF;
    @(negedge clk);
    release dut.cap_cnt_reg;
    @(negedge clk);
    chk("sat_pre", 32'(cap_cnt), 32'h0000FFFF);
    txn(13'h0F0F, 1'b1);
    chk("sat_post", 32'(cap_cnt), 32'h0000FFFF);
    chk("sat_sig",  32'(sig),     32'h0001);

    // SETTLE_CYC=4: glitches during T0+1..T0+3 must not be captured
    bus4.vec_valid = 1'b1;
    bus4.vec_data  = 13'h0F0F;
    cone_out4      = 1'b0;
    @(negedge clk);
    bus4.vec_valid = 1'b0;
    cone_out4      = 1'b1;
    chk("s4_cone_in", 32'(cone_in4), 32'h0F0F);
    @(negedge clk);
    chk("s4_wait1", 32'(bus4.res_valid), 32'd0);
    @(negedge clk);
    chk("s4_wait2", 32'(bus4.res_valid), 32'd0);
    @(negedge clk);
    chk("s4_wait3", 32'(bus4.res_valid), 32'd0);
    cone_out4 = 1'b0;
    @(negedge clk);
    chk("s4_res_valid", 32'(bus4.res_valid), 32'd1);
    chk("s4_res_bit",   32'(bus4.res_bit),   32'd0);
    chk("s4_cap_cnt",   32'(cap_cnt4),       32'd1);
    bus4.res_ready = 1'b1;
    @(negedge clk);
    bus4.res_ready = 1'b0;
    bus4.vec_valid = 1'b1;
    bus4.vec_data  = 13'h10F0;
    @(negedge clk);
    bus4.vec_valid = 1'b0;
    cone_out4      = 1'b0;
    repeat (3) @(negedge clk);
    cone_out4 = 1'b1;
    @(negedge clk);
    chk("s4b_res_bit", 32'(bus4.res_bit), 32'd1);
    chk("s4b_sig",     32'(sig4),         32'h0001);
    bus4.res_ready = 1'b1;
    @(negedge clk);
    bus4.res_ready = 1'b0;

    // Reset pulse while in WAIT (default instance)
    bus.vec_valid = 1'b1;
    bus.vec_data  = 13'h1234;
    cone_out      = 1'b1;
    @(negedge clk);
    bus.vec_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rw_vec_ready", 32'(bus.vec_ready), 32'd1);
    chk("rw_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rw_res_bit",   32'(bus.res_bit),   32'd0);
    chk("rw_cone_in",   32'(cone_in),       32'h0);
    chk("rw_sig",       32'(sig),           32'h0000);
    chk("rw_cap_cnt",   32'(cap_cnt),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rw_after_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rw_after_cap_cnt",   32'(cap_cnt),       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_cone_launch_capture.md
Name: aes_cone_launch_capture

Overview:
- Registered launch/capture stage wrapped around one combinational AES timing cone (13 inputs, 1 output).
- Accepts an input vector over a valid/ready handshake and launches it from flops onto the cone inputs.
- Waits a programmable settle time, then captures the cone output bit and presents it downstream over valid/ready.
- Folds every captured bit into a MISR signature and counts captures, for bulk regression against the gate-level cone.

Parameters:
- IN_W, 13, cone input width.
- SETTLE_CYC, 1, cycles between launch and capture; legal range 1..15.
- MISR_W, 16, signature width.
- MISR_POLY, 16'h1021, MISR feedback polynomial; taps applied when the MSB shifts out.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vec_valid  in  1  upstream vector valid.
- vec_data  in  IN_W  upstream vector; bit i drives cone input n_i.
- vec_ready  out  1  stage can accept a vector.
- cone_in  out  IN_W  registered drive to the cone inputs.
- cone_out  in  1  cone output (n_27).
- res_valid  out  1  captured result valid.
- res_bit  out  1  captured cone output.
- res_ready  in  1  downstream accepts the result.
- clear  in  1  synchronous clear of the signature and counter.
- sig  out  MISR_W  running MISR signature.
- cap_cnt  out  16  number of captures, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - cone_in, res_bit, sig, cap_cnt = 0.
  - res_valid=0.
  - settle counter = 0.
  - Reset asserted mid-operation abandons the transaction; no partial result is kept.
- FSM states: IDLE, WAIT, RESULT.
- IDLE:
  - vec_ready=1, res_valid=0.
  - On vec_valid at an edge: cone_in<=vec_data, settle counter<=SETTLE_CYC-1, go to WAIT.
- WAIT:
  - vec_ready=0.
  - If the counter is nonzero, decrement it.
  - If the counter is zero: res_bit<=cone_out, MISR update, cap_cnt update, go to RESULT.
  - Capture edge = accept edge + SETTLE_CYC; with the default, res_valid is high one cycle after acceptance.
- RESULT:
  - res_valid=1, vec_ready=0, res_bit is held stable.
  - On res_ready: go to IDLE (res_valid low the next cycle).
  - No back-to-back overlap: a new vector is accepted no earlier than the cycle after the result handshake.
- cone_in holds its last launched value in every state until the next accept; it never returns to 0 except on reset.
- MISR update: sig <= ({sig[MISR_W-2:0],1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : 0)) ^ {{MISR_W-1{1'b0}}, res_bit_new}.
- cap_cnt increments by 1 per capture and saturates at 16'hFFFF (no wrap).
- clear:
  - Zeroes sig and cap_cnt at the next edge in any state; FSM, cone_in and res_bit are unaffected.
  - If clear coincides with a capture edge, clear wins: sig=0 and cap_cnt=0; the captured bit is still presented on res_bit.
- vec_valid while vec_ready=0 is ignored and does not need to be held by the stage; upstream must keep it asserted per the handshake.
- res_ready while res_valid=0 is ignored.

Decomposition:
- Package aes_cone_pkg holds:
  - state enum {IDLE, WAIT, RESULT}.
  - default MISR_POLY constant.
  - cone input width constant 13.
- One natural sub-module, aes_cone_misr: a MISR_W-bit register with shift, polynomial feedback, data-in XOR and synchronous clear, sharing clk/rst_n.

Test Plan:
- Reset, then idle: hold rst_n=0 for 3 cycles, release -> vec_ready=1, res_valid=0, sig=0x0000, cap_cnt=0, cone_in=0.
- Single transaction, SETTLE_CYC=1: vec_data=13'h1ABC accepted at edge T0, stub drives cone_out=1 -> cone_in=13'h1ABC after T0; res_valid=1, res_bit=1 after T0+1; sig=0x0001, cap_cnt=1.
- MISR feedback: preload sig=0x8000 via a prior sequence, capture cone_out=0 -> sig=0x1021; capture cone_out=1 from sig=0x0001 -> sig=0x0003.
- Backpressure: hold res_ready=0 for 5 cycles with vec_valid=1 -> res_valid stays 1, res_bit stable, vec_ready=0, no second accept; release res_ready -> IDLE the next cycle, then accept.
- SETTLE_CYC=4 build: accept at T0 -> cone_out sampled at T0+4; glitch cone_out during T0+1..T0+3 -> glitch not captured.
- Boundaries:
  - clear asserted on a capture edge -> sig=0, cap_cnt=0, res_valid=1.
  - Force cap_cnt=0xFFFF and capture -> stays 0xFFFF.
  - rst_n pulse while in WAIT -> IDLE with all outputs 0.
